stopwatch_ctrl: RTL and testbench

Run/pause/lap/clear sequencer for the stopwatch datapath. Takes the user buttons and the divided time-base clock from the gated clock divider. Drives the divider's run gate, keeps the mm:ss BCD elapsed-time count, and supplies the display value, which is live or a frozen lap capture. Sits between the button inputs and the clock divider, 7-segment decoder and display mux.

---
 rtl/sw_pkg.sv | 56 +++++
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/sw_sync_edge.sv | 34 +++
 rtl/stopwatch_ctrl.sv | 112 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared types and constants for the stopwatch controller: FSM encoding,
// BCD digit type and the mm:ss increment helper.
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  typedef logic [3:0] digit_t;

  localparam digit_t SEC_ONES_MAX = 4'd9;
  localparam digit_t SEC_TENS_MAX = 4'd5;
  localparam digit_t MIN_ONES_MAX = 4'd9;
  localparam digit_t MIN_TENS_MAX = 4'd5;

  typedef struct packed {
    logic        wrap;
    logic [15:0] value;
  } bcd_inc_t;

  // One-second increment of {min_tens, min_ones, sec_tens, sec_ones}; the
  // tens limits are arguments so the moduli can be overridden.
  function automatic bcd_inc_t bcd_inc(input logic [15:0] t,
                                       input digit_t sec_tens_last,
                                       input digit_t min_tens_last);
    bcd_inc_t r;
    r.value = t;
    r.wrap  = 1'b0;
    if (t[3:0] != SEC_ONES_MAX) begin
      r.value[3:0] = t[3:0] + 4'd1;
    end else begin
      r.value[3:0] = 4'd0;
      if (t[7:4] != sec_tens_last) begin
        r.value[7:4] = t[7:4] + 4'd1;
      end else begin
        r.value[7:4] = 4'd0;
        if (t[11:8] != MIN_ONES_MAX) begin
          r.value[11:8] = t[11:8] + 4'd1;
        end else begin
          r.value[11:8] = 4'd0;
          if (t[15:12] != min_tens_last) begin
            r.value[15:12] = t[15:12] + 4'd1;
          end else begin
            r.value[15:12] = 4'd0;
            r.wrap         = 1'b1;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/tick inputs and display/run-gate outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import sw_pkg::*;

  logic        btn_start;
  logic        btn_lap;
  logic        btn_clear;
  logic        tick_in;
  logic        run_en;
  logic [15:0] disp_time;
  logic        lap_active;
  state_t      state;
  logic        wrap;

  modport master (
    output btn_start, btn_lap, btn_clear, tick_in,
    input  run_en, disp_time, lap_active, state, wrap
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear, tick_in,
    output run_en, disp_time, lap_active, state, wrap
  );
endinterface

// File: rtl/sw_sync_edge.sv
// Synchroniser chain for one asynchronous level input, followed by a
// rising-edge detector producing a single-cycle pulse.
module sw_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sub_clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;

  always_ff @(posedge sub_clk or negedge rst) begin
    if (!rst) sync_reg[0] <= 1'b0;
    else      sync_reg[0] <= async_in;
  end

  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
    always_ff @(posedge sub_clk or negedge rst) begin
      if (!rst) sync_reg[gi] <= 1'b0;
      else      sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  always_ff @(posedge sub_clk or negedge rst) begin
    if (!rst) prev_reg <= 1'b0;
    else      prev_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign pulse = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/lap/clear sequencer: conditions the buttons and time-base tick,
// keeps the mm:ss BCD count and lap capture, and drives run gate and display.
module stopwatch_ctrl
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SEC_WRAP    = 60,
  parameter int MIN_WRAP    = 60
) (
  input  logic           sub_clk,
  input  logic           rst,
  stopwatch_ctrl_if.slave sw
);

  localparam digit_t SEC_TENS_LAST = digit_t'(SEC_WRAP / 10 - 1);
  localparam digit_t MIN_TENS_LAST = digit_t'(MIN_WRAP / 10 - 1);

  // Bit order: 0 start, 1 lap, 2 clear, 3 tick.
  logic [3:0] raw_in;
  logic [3:0] pulses;
  logic       start_p, lap_p, clear_p, tick_p;

  assign raw_in = {sw.tick_in, sw.btn_clear, sw.btn_lap, sw.btn_start};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    sw_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sub_clk  (sub_clk),
      .rst      (rst),
      .async_in (raw_in[gi]),
      .pulse    (pulses[gi])
    );
  end

  assign start_p = pulses[0];
  assign lap_p   = pulses[1];
  assign clear_p = pulses[2];
  assign tick_p  = pulses[3];

  state_t      state_reg, state_next;
  logic [15:0] count_reg, count_next;
  logic [15:0] lap_reg, lap_next;
  logic        wrap_reg, wrap_next;
  logic        run_en_reg;
  logic [15:0] disp_reg;
  logic        lap_active_reg;
  bcd_inc_t    inc;

  assign inc = bcd_inc(count_reg, SEC_TENS_LAST, MIN_TENS_LAST);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    lap_next   = lap_reg;
    wrap_next  = 1'b0;

    // Ticks only count from the registered state, so a start from IDLE or
    // PAUSE never picks up a tick arriving in the same cycle.
    if (tick_p && (state_reg == RUN || state_reg == LAP)) begin
      count_next = inc.value;
      wrap_next  = inc.wrap;
    end

    if (clear_p) begin
      state_next = IDLE;
      count_next = 16'h0000;
      lap_next   = 16'h0000;
      wrap_next  = 1'b0;
    end else if (start_p) begin
      unique case (state_reg)
        IDLE:  state_next = RUN;
        RUN:   state_next = PAUSE;
        LAP:   state_next = PAUSE;
        PAUSE: state_next = RUN;
        default: state_next = IDLE;
      endcase
    end else if (lap_p) begin
      if (state_reg == RUN) begin
        state_next = LAP;
        lap_next   = count_reg;
      end else if (state_reg == LAP) begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge sub_clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      count_reg      <= 16'h0000;
      lap_reg        <= 16'h0000;
      wrap_reg       <= 1'b0;
      run_en_reg     <= 1'b0;
      disp_reg       <= 16'h0000;
      lap_active_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      lap_reg        <= lap_next;
      wrap_reg       <= wrap_next;
      run_en_reg     <= (state_next == RUN) || (state_next == LAP);
      disp_reg       <= (state_reg == LAP) ? lap_reg : count_reg;
      lap_active_reg <= (state_reg == LAP);
    end
  end

  assign sw.state      = state_reg;
  assign sw.run_en     = run_en_reg;
  assign sw.disp_time  = disp_reg;
  assign sw.lap_active = lap_active_reg;
  assign sw.wrap       = wrap_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized
// button/tick sequences against an elapsed-seconds reference model.
module tb_stopwatch_ctrl;
  import sw_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wrap_seen = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.SYNC_STAGES(2), .SEC_WRAP(60), .MIN_WRAP(60)) dut (
    .sub_clk (clk),
    .rst     (rst),
    .sw      (sw_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sw_if.wrap === 1'b1) wrap_seen++;

  // Reference model: elapsed seconds and user-visible mode flags.
  int m_elapsed, m_lap;
  bit m_running, m_frozen, m_started;

  function automatic logic [15:0] to_bcd(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic state_t exp_state();
    if (!m_running) return m_started ? PAUSE : IDLE;
    return m_frozen ? LAP : RUN;
  endfunction

  function automatic logic [15:0] exp_disp();
    return to_bcd(m_frozen ? m_lap : m_elapsed);
  endfunction

  task automatic model_reset();
    m_elapsed = 0; m_lap = 0; m_running = 0; m_frozen = 0; m_started = 0;
  endtask

  task automatic model_apply(input bit s, input bit l, input bit c, input bit t);
    int pre;
    pre = m_elapsed;
    if (c) begin
      model_reset();
      return;
    end
    if (t && m_running) m_elapsed = (m_elapsed + 1) % 3600;
    if (s) begin
      m_started = 1;
      m_running = !m_running;
      m_frozen  = 0;
    end else if (l && m_running) begin
      if (!m_frozen) m_lap = pre;
      m_frozen = !m_frozen;
    end
  endtask

  task automatic press(input bit s, input bit l, input bit c, input bit t);
    @(negedge clk);
    sw_if.btn_start = s; sw_if.btn_lap = l; sw_if.btn_clear = c; sw_if.tick_in = t;
    repeat (2) @(negedge clk);
    sw_if.btn_start = 0; sw_if.btn_lap = 0; sw_if.btn_clear = 0; sw_if.tick_in = 0;
    repeat (4) @(negedge clk);
    model_apply(s, l, c, t);
    $display("press start=%0b lap=%0b clear=%0b tick=%0b -> state=%0d disp=%h",
             s, l, c, t, sw_if.state, sw_if.disp_time);
  endtask

  task automatic fast_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sw_if.tick_in = 1;
      @(negedge clk); sw_if.tick_in = 0;
      model_apply(0, 0, 0, 1);
    end
    repeat (4) @(negedge clk);
    $display("ticks n=%0d -> state=%0d disp=%h", n, sw_if.state, sw_if.disp_time);
  endtask

  task automatic test_reset();
    rst = 0;
    sw_if.btn_start = 0; sw_if.btn_lap = 0; sw_if.btn_clear = 0; sw_if.tick_in = 0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    checks++; if (sw_if.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", sw_if.state, IDLE); end
    checks++; if (sw_if.run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en got %b want 0", sw_if.run_en); end
    checks++; if (sw_if.disp_time !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h want 0000", sw_if.disp_time); end
    checks++; if ({sw_if.lap_active, sw_if.wrap} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {sw_if.lap_active, sw_if.wrap}); end
  endtask

  task automatic test_idle_ticks();
    fast_ticks(5);
    checks++; if (sw_if.disp_time !== exp_disp()) begin errors++; $display("FAIL idle_ticks_disp got %h want %h", sw_if.disp_time, exp_disp()); end
    checks++; if (sw_if.state !== exp_state() || sw_if.run_en !== 1'b0) begin errors++; $display("FAIL idle_ticks_state got %0d/%b want %0d/0", sw_if.state, sw_if.run_en, exp_state()); end
  endtask

  task automatic test_run_pause();
    press(1, 0, 0, 0);
    fast_ticks(75);
    checks++; if (sw_if.run_en !== 1'b1) begin errors++; $display("FAIL run_en_running got %b want 1", sw_if.run_en); end
    press(1, 0, 0, 0);
    checks++; if (sw_if.state !== PAUSE || sw_if.run_en !== 1'b0) begin errors++; $display("FAIL pause_state got %0d/%b want %0d/0", sw_if.state, sw_if.run_en, PAUSE); end
    checks++; if (sw_if.disp_time !== 16'h0115) begin errors++; $display("FAIL pause_disp got %h want 0115", sw_if.disp_time); end
    fast_ticks(3);
    checks++; if (sw_if.disp_time !== 16'h0115) begin errors++; $display("FAIL pause_ticks_disp got %h want 0115", sw_if.disp_time); end
  endtask

  task automatic test_wrap();
    int w0;
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    fast_ticks(3598);
    checks++; if (sw_if.disp_time !== 16'h5958) begin errors++; $display("FAIL wrap_pre got %h want 5958", sw_if.disp_time); end
    w0 = wrap_seen;
    fast_ticks(1);
    checks++; if (sw_if.disp_time !== 16'h5959 || wrap_seen != w0) begin errors++; $display("FAIL wrap_5959 got %h/%0d want 5959/0", sw_if.disp_time, wrap_seen - w0); end
    fast_ticks(1);
    checks++; if (sw_if.disp_time !== to_bcd(m_elapsed) || sw_if.disp_time !== 16'h0000) begin errors++; $display("FAIL wrap_0000 got %h want 0000", sw_if.disp_time); end
    checks++; if (wrap_seen - w0 != 1) begin errors++; $display("FAIL wrap_pulse_cycles got %0d want 1", wrap_seen - w0); end
    checks++; if (sw_if.run_en !== 1'b1) begin errors++; $display("FAIL wrap_run_en got %b want 1", sw_if.run_en); end
  endtask

  task automatic test_lap();
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    fast_ticks(12);
    press(0, 1, 0, 0);
    fast_ticks(5);
    checks++; if (sw_if.disp_time !== 16'h0012 || sw_if.lap_active !== 1'b1) begin errors++; $display("FAIL lap_frozen got %h/%b want 0012/1", sw_if.disp_time, sw_if.lap_active); end
    press(0, 1, 0, 0);
    checks++; if (sw_if.disp_time !== 16'h0017 || sw_if.lap_active !== 1'b0) begin errors++; $display("FAIL lap_release got %h/%b want 0017/0", sw_if.disp_time, sw_if.lap_active); end
  endtask

  task automatic test_same_cycle();
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    fast_ticks(30);
    press(1, 0, 1, 1);
    checks++; if (sw_if.state !== IDLE || sw_if.disp_time !== 16'h0000 || sw_if.run_en !== 1'b0) begin errors++; $display("FAIL clear_start_tick got %0d/%h/%b want %0d/0000/0", sw_if.state, sw_if.disp_time, sw_if.run_en, IDLE); end
    press(1, 0, 0, 0);
    fast_ticks(30);
    press(1, 0, 0, 1);
    checks++; if (sw_if.state !== PAUSE || sw_if.disp_time !== 16'h0031) begin errors++; $display("FAIL start_tick got %0d/%h want %0d/0031", sw_if.state, sw_if.disp_time, PAUSE); end
  endtask

  task automatic test_held_and_async_reset();
    press(0, 0, 1, 0);
    @(negedge clk); sw_if.btn_start = 1;
    repeat (100) @(negedge clk);
    sw_if.btn_start = 0;
    repeat (4) @(negedge clk);
    model_apply(1, 0, 0, 0);
    checks++; if (sw_if.state !== exp_state() || sw_if.state !== RUN) begin errors++; $display("FAIL held_button got %0d want %0d", sw_if.state, RUN); end
    fast_ticks(42);
    checks++; if (sw_if.disp_time !== 16'h0042) begin errors++; $display("FAIL pre_reset_disp got %h want 0042", sw_if.disp_time); end
    @(negedge clk); #1 rst = 0;
    #1;
    checks++; if ({sw_if.state, sw_if.run_en, sw_if.disp_time, sw_if.lap_active, sw_if.wrap} !== 21'd0) begin errors++; $display("FAIL async_reset got %0d/%b/%h/%b/%b want all 0", sw_if.state, sw_if.run_en, sw_if.disp_time, sw_if.lap_active, sw_if.wrap); end
    model_reset();
    @(negedge clk); rst = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        fast_ticks($urandom_range(1, 15));
      end else begin
        press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
      end
      checks++; if (sw_if.state !== exp_state()) begin errors++; $display("FAIL rand_state[%0d] got %0d want %0d", i, sw_if.state, exp_state()); end
      checks++; if (sw_if.run_en !== m_running) begin errors++; $display("FAIL rand_run_en[%0d] got %b want %b", i, sw_if.run_en, m_running); end
      checks++; if (sw_if.disp_time !== exp_disp()) begin errors++; $display("FAIL rand_disp[%0d] got %h want %h", i, sw_if.disp_time, exp_disp()); end
      checks++; if (sw_if.lap_active !== m_frozen) begin errors++; $display("FAIL rand_lap_active[%0d] got %b want %b", i, sw_if.lap_active, m_frozen); end
    end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_run_pause();
    test_wrap();
    test_lap();
    test_same_cycle();
    test_held_and_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
